// File: rtl/tpu_ctrl_pkg.sv
// tpu_ctrl_pkg
// Shared definitions for the systolic-array control blocks.
//   seq_state_t : sequencer FSM encoding (3 bits)
//   cnt_width() : width of the RUN-phase cycle counter. It is sized so that
//                 the largest count, M + 2*WIDTH_HEIGHT - 2, never wraps.
package tpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_REQ  = 3'd1,
    LOAD_WAIT = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } seq_state_t;

  function automatic int cnt_width(input int row_width, input int wh);
    return row_width + $clog2(wh) + 2;
  endfunction

endpackage

// File: rtl/stagger_mask.sv
// stagger_mask
// Decodes the RUN counter into a staggered window mask. Lane i is high while
// OFFSET+i <= t < OFFSET+i+m, so each lane is open for exactly m cycles,
// one cycle after the lane before it.
// Ports:
//   en   : in  1      window enable (high only in RUN)
//   t    : in  CNT_W  RUN cycle counter
//   m    : in  CNT_W  latched row count, zero-extended
//   mask : out WIDTH_HEIGHT  per-lane enable
import tpu_ctrl_pkg::*;

module stagger_mask #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int OFFSET       = 0,
  parameter int CNT_W        = 14
) (
  input  logic                    en,
  input  logic [CNT_W-1:0]        t,
  input  logic [CNT_W-1:0]        m,
  output logic [WIDTH_HEIGHT-1:0] mask
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH_HEIGHT; gi++) begin : g_lane
      localparam logic [CNT_W-1:0] LO = CNT_W'(gi + OFFSET);
      // CNT_W leaves headroom above LO + m, so the sum cannot overflow.
      assign mask[gi] = en && (t >= LO) && (t < LO + m);
    end
  endgenerate

endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer
// Sequences one matrix-multiply pass: optional weight-FIFO load handshake,
// then staggered input-FIFO pops and accumulator writes, then a done pulse.
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-low reset
//   start             : command request, taken only while ready
//   num_rows          : input-vector count M, latched on acceptance
//   reuse_weights     : skip weight load, latched on acceptance
//   stagger_load      : weight load mode, latched on acceptance
//   ready / busy      : IDLE indication and its complement
//   wfifo_active      : one-cycle weight-load request
//   wfifo_stagger     : latched stagger_load
//   wfifo_done        : weight controller idle level (low while loading)
//   data_fifo_en      : per-row input-FIFO pop enables
//   acc_en            : per-column accumulator write enables
//   done              : one-cycle completion pulse
import tpu_ctrl_pkg::*;

module systolic_sequencer #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ROW_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ROW_WIDTH-1:0]    num_rows,
  input  logic                    reuse_weights,
  input  logic                    stagger_load,
  output logic                    ready,
  output logic                    busy,
  output logic                    wfifo_active,
  output logic                    wfifo_stagger,
  input  logic                    wfifo_done,
  output logic [WIDTH_HEIGHT-1:0] data_fifo_en,
  output logic [WIDTH_HEIGHT-1:0] acc_en,
  output logic                    done
);

  localparam int CNT_W = cnt_width(ROW_WIDTH, WIDTH_HEIGHT);
  localparam logic [CNT_W-1:0] RUN_TAIL = CNT_W'(2 * WIDTH_HEIGHT - 2);

  seq_state_t           state;
  logic [CNT_W-1:0]     t;
  logic [ROW_WIDTH-1:0] m_lat;
  logic                 reuse_lat;
  logic                 stag_lat;
  logic                 seen_busy;
  logic [CNT_W-1:0]     m_ext;
  logic                 run_on;

  assign m_ext  = CNT_W'(m_lat);
  assign run_on = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      t         <= '0;
      m_lat     <= '0;
      reuse_lat <= 1'b0;
      stag_lat  <= 1'b0;
      seen_busy <= 1'b0;
    end else begin
      // t only advances in RUN; every other state parks it at zero so RUN
      // always begins counting from 0.
      t <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            m_lat     <= num_rows;
            reuse_lat <= reuse_weights;
            stag_lat  <= stagger_load;
            if (!reuse_weights) begin
              state     <= LOAD_REQ;
              seen_busy <= 1'b0;
            end else if (num_rows == '0) begin
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        LOAD_REQ: state <= LOAD_WAIT;
        LOAD_WAIT: begin
          // A done level still high from before the request must not end
          // the wait; only a high after an observed low counts.
          if (wfifo_done && seen_busy) begin
            state <= (m_lat == '0) ? DONE : RUN;
          end else if (!wfifo_done) begin
            seen_busy <= 1'b1;
          end
        end
        RUN: begin
          // Last accumulator column closes at t = M + 2*WH - 2.
          if (t == m_ext + RUN_TAIL) begin
            state <= DONE;
          end else begin
            t <= t + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready         = (state == IDLE);
  assign busy          = ~ready;
  assign wfifo_active  = (state == LOAD_REQ) && !reuse_lat;
  assign wfifo_stagger = stag_lat;
  assign done          = (state == DONE);

  stagger_mask #(
    .WIDTH_HEIGHT(WIDTH_HEIGHT),
    .OFFSET      (0),
    .CNT_W       (CNT_W)
  ) u_row_mask (
    .en  (run_on),
    .t   (t),
    .m   (m_ext),
    .mask(data_fifo_en)
  );

  stagger_mask #(
    .WIDTH_HEIGHT(WIDTH_HEIGHT),
    .OFFSET      (WIDTH_HEIGHT),
    .CNT_W       (CNT_W)
  ) u_col_mask (
    .en  (run_on),
    .t   (t),
    .m   (m_ext),
    .mask(acc_en)
  );

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer
// Drives a list of commands (directed plus random) into the sequencer with a
// simple weight-controller model on wfifo_done, and compares every output
// each cycle against a timeline model: each accepted command is reduced to
// the cycle numbers of its request, RUN window and done pulse.
module tb_systolic_sequencer;

  localparam int WH = 4;
  localparam int RW = 8;
  localparam int CYCLE_LIMIT = 30000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] num_rows = '0;
  logic          reuse_weights = 1'b0;
  logic          stagger_load = 1'b0;
  logic          wfifo_done = 1'b1;
  logic          ready, busy, wfifo_active, wfifo_stagger, done;
  logic [WH-1:0] data_fifo_en, acc_en;

  systolic_sequencer #(.WIDTH_HEIGHT(WH), .ROW_WIDTH(RW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_rows     (num_rows),
    .reuse_weights(reuse_weights),
    .stagger_load (stagger_load),
    .ready        (ready),
    .busy         (busy),
    .wfifo_active (wfifo_active),
    .wfifo_stagger(wfifo_stagger),
    .wfifo_done   (wfifo_done),
    .data_fifo_en (data_fifo_en),
    .acc_en       (acc_en),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int m; bit reuse; bit stag; int d1; int d0; int gap; bit rst;
  } cmd_t;
  cmd_t cmds[$];

  // Timeline model state
  int cyc = 0;
  bit cmd_on = 0;
  bit wait_on = 0;
  bit seen0 = 0;
  bit stag_l = 0;
  bit cur_rst = 0;
  int req_cyc = -1, run_start = -1, done_cyc = -1;
  int mm = 0, wd1 = 0, wd0 = 1;
  int cmd_idx = 0, gap = 0, cur_id = 0;

  function automatic logic [WH-1:0] window(input int t, input int m, input int base);
    logic [WH-1:0] w;
    w = '0;
    for (int i = 0; i < WH; i++)
      if (t >= i + base && t < i + base + m) w[i] = 1'b1;
    return w;
  endfunction

  task automatic check_idle_outputs(input string when);
    check_eq({when, "_ready"}, ready, 1);
    check_eq({when, "_busy"}, busy, 0);
    check_eq({when, "_wfifo_active"}, wfifo_active, 0);
    check_eq({when, "_wfifo_stagger"}, wfifo_stagger, 0);
    check_eq({when, "_data_fifo_en"}, data_fifo_en, 0);
    check_eq({when, "_acc_en"}, acc_en, 0);
    check_eq({when, "_done"}, done, 0);
  endtask

  initial begin
    bit exp_ready, running, accept;
    int t;
    cmd_t c;

    // Directed commands first, then random ones.
    cmds.push_back('{m: 3,   reuse: 0, stag: 1, d1: 2, d0: 4, gap: 10, rst: 0});
    cmds.push_back('{m: 1,   reuse: 1, stag: 0, d1: 0, d0: 1, gap: 2,  rst: 0});
    cmds.push_back('{m: 0,   reuse: 0, stag: 1, d1: 1, d0: 2, gap: 1,  rst: 0});
    cmds.push_back('{m: 2,   reuse: 1, stag: 1, d1: 0, d0: 1, gap: 1,  rst: 1});
    cmds.push_back('{m: 3,   reuse: 0, stag: 0, d1: 0, d0: 1, gap: 1,  rst: 0});
    cmds.push_back('{m: 2,   reuse: 1, stag: 1, d1: 0, d0: 1, gap: 0,  rst: 0});
    cmds.push_back('{m: 2,   reuse: 0, stag: 0, d1: 3, d0: 2, gap: 0,  rst: 0});
    cmds.push_back('{m: 0,   reuse: 1, stag: 1, d1: 0, d0: 1, gap: 0,  rst: 0});
    cmds.push_back('{m: 255, reuse: 1, stag: 0, d1: 0, d0: 1, gap: 2,  rst: 0});
    for (int i = 0; i < 30; i++) begin
      c.m     = ($urandom % 8 == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
      c.reuse = $urandom_range(0, 1);
      c.stag  = $urandom_range(0, 1);
      c.d1    = $urandom_range(0, 3);
      c.d0    = $urandom_range(1, 5);
      c.gap   = $urandom_range(0, 3);
      c.rst   = ($urandom % 10 == 0);
      cmds.push_back(c);
    end

    // Reset values, checked while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    gap = cmds[0].gap;

    while ((cmd_idx < cmds.size() || cmd_on) && cyc < CYCLE_LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;

      // Expected outputs for this cycle.
      exp_ready = !cmd_on;
      running   = cmd_on && run_start >= 0 && cyc >= run_start && cyc < done_cyc;
      t         = running ? cyc - run_start : 0;
      check_eq("ready", ready, exp_ready);
      check_eq("busy", busy, !exp_ready);
      check_eq("wfifo_active", wfifo_active, cmd_on && cyc == req_cyc);
      check_eq("data_fifo_en", data_fifo_en, running ? window(t, mm, 0) : '0);
      check_eq("acc_en", acc_en, running ? window(t, mm, WH) : '0);
      check_eq("done", done, cmd_on && cyc == done_cyc);
      if (cmd_on) check_eq("wfifo_stagger", wfifo_stagger, stag_l);

      // Asynchronous reset in the middle of RUN.
      if (running && t == 2 && cur_rst) begin
        start = 1'b0;
        wfifo_done = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        $display("cmd %0d: M=%0d aborted by reset at t=2", cur_id, mm);
        cmd_on = 0; wait_on = 0; req_cyc = -1; run_start = -1; done_cyc = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        continue;
      end

      // Inputs for the next edge.
      if (!cmd_on) begin
        if (gap > 0 || cmd_idx >= cmds.size()) begin
          if (gap > 0) gap--;
          start = 1'b0;
          num_rows = RW'($urandom);
          reuse_weights = $urandom_range(0, 1);
          stagger_load = $urandom_range(0, 1);
        end else begin
          start = 1'b1;
          num_rows = RW'(cmds[cmd_idx].m);
          reuse_weights = cmds[cmd_idx].reuse;
          stagger_load = cmds[cmd_idx].stag;
        end
      end else begin
        // Busy: these inputs must be ignored.
        start = $urandom_range(0, 1);
        num_rows = RW'($urandom);
        reuse_weights = $urandom_range(0, 1);
        stagger_load = $urandom_range(0, 1);
      end
      // Weight controller: idle-high, low for wd0 cycles starting wd1
      // cycles after the request cycle.
      wfifo_done = !(req_cyc >= 0 && cyc >= req_cyc + 1 + wd1 && cyc < req_cyc + 1 + wd1 + wd0);

      // Model update.
      accept = exp_ready && start;
      if (cmd_on && wait_on && cyc >= req_cyc + 1) begin
        if (wfifo_done && seen0) begin
          wait_on = 0;
          if (mm == 0) begin
            done_cyc = cyc + 1;
          end else begin
            run_start = cyc + 1;
            done_cyc  = cyc + 1 + mm + 2 * WH - 1;
          end
        end else if (!wfifo_done) begin
          seen0 = 1;
        end
      end
      if (cmd_on && cyc == done_cyc) begin
        $display("cmd %0d: M=%0d reuse=%0d done in cycle %0d", cur_id, mm, !(req_cyc >= 0), cyc);
        cmd_on = 0;
        req_cyc = -1;
      end
      if (accept) begin
        c = cmds[cmd_idx];
        cur_id = cmd_idx;
        cmd_idx++;
        gap = (cmd_idx < cmds.size()) ? cmds[cmd_idx].gap : 0;
        cmd_on = 1; mm = c.m; stag_l = c.stag; cur_rst = c.rst;
        wd1 = c.d1; wd0 = c.d0; seen0 = 0;
        run_start = -1; done_cyc = -1;
        if (!c.reuse) begin
          req_cyc = cyc + 1;
          wait_on = 1;
        end else begin
          req_cyc = -1;
          wait_on = 0;
          if (c.m == 0) begin
            done_cyc = cyc + 1;
          end else begin
            run_start = cyc + 1;
            done_cyc  = cyc + 1 + c.m + 2 * WH - 1;
          end
        end
      end
    end

    check_eq("all_cmds_completed", cmd_idx, cmds.size());
    check_eq("cycle_budget", cyc < CYCLE_LIMIT, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
